// File: rtl/spi_cfg_loader_if.sv
// SPI pin bundle for the configuration loader.
// The master drives clock, select and data; the slave returns readback.
interface spi_cfg_loader_if;
  logic spi_clk;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_csn,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_csn,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_cfg_loader.sv
// SPI configuration loader: oversampled SPI slave that commits a DW-bit
// frame atomically to the FM transmitter config and reads the old one back.
module spi_cfg_loader #(
  parameter int          N             = 18,
  parameter int          L             = 12,
  parameter int          D             = 5,
  parameter int unsigned ACC_INC_DEF   = 52428,
  parameter int unsigned DF_INC_DEF    = 393,
  parameter logic [D-1:0] DAC_ENA_DEF  = '1,
  parameter int unsigned DITH_FACT_DEF = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_cfg_loader_if.slave     spi,
  input  logic                usb_i2sn_pin,
  input  logic                audio_chan_sel_pin,
  input  logic                i2s_ws_align_pin,
  input  logic                dith_disable_pin,
  output logic [N-1:0]        acc_inc,
  output logic [L-1:0]        df_inc,
  output logic [D-1:0]        dac_ena,
  output logic [2:0]          dith_fact,
  output logic                usb_i2sn,
  output logic                audio_chan_sel,
  output logic                i2s_ws_align,
  output logic                cfg_update,
  output logic                frame_err
);

  localparam int DW     = N + L + D + 7;
  localparam int CW     = $clog2(DW + 2);
  localparam int P_DF   = N;
  localparam int P_DAC  = N + L;
  localparam int P_DITH = N + L + D;
  localparam int P_USB  = P_DITH + 3;
  localparam int P_AUD  = P_USB + 1;
  localparam int P_WS   = P_USB + 2;
  localparam int P_OVR  = DW - 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

  localparam logic [DW-1:0] ACTIVE_DEF = {
    1'b0, 3'b000, 3'(DITH_FACT_DEF), DAC_ENA_DEF,
    L'(DF_INC_DEF), N'(ACC_INC_DEF)
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_active;
  logic [DW-1:0]   r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_miso;
  logic            r_cfg_update;
  logic            r_frame_err;

  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_csn_s1, r_csn_s2, r_csn_d;
  logic r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic [1:0] r_flush;
  logic r_armed;

  logic w_clk_rise;
  logic w_clk_fall;
  logic w_csn_rise;
  logic w_csn_fall;
  logic w_ovr;

  // Two-flop synchronisers plus one edge-detect stage per SPI pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1  <= 1'b0;
      r_clk_s2  <= 1'b0;
      r_clk_d   <= 1'b0;
      r_csn_s1  <= 1'b1;
      r_csn_s2  <= 1'b1;
      r_csn_d   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_d  <= 1'b0;
    end else begin
      r_clk_s1  <= spi.spi_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_d   <= r_clk_s2;
      r_csn_s1  <= spi.spi_csn;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_mosi_s1 <= spi.spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_d  <= r_mosi_s2;
    end
  end

  // Arm frame start only once csn is seen high after the synchroniser
  // has flushed its reset value, so a low csn at reset release is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && r_csn_s2)
        r_armed <= 1'b1;
    end
  end

  assign w_clk_rise = r_clk_s2 & ~r_clk_d;
  assign w_clk_fall = ~r_clk_s2 & r_clk_d;
  assign w_csn_rise = r_csn_s2 & ~r_csn_d;
  assign w_csn_fall = ~r_csn_s2 & r_csn_d & r_armed;

  // Frame FSM: shift in, shift out readback, commit on exact bit count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_active     <= ACTIVE_DEF;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_miso       <= 1'b0;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cfg_update <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_csn_fall) begin
            r_shift <= r_active;
            r_miso  <= r_active[DW-1];
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_clk_rise) begin
            r_shift <= {r_shift[DW-2:0], r_mosi_d};
            if (r_cnt != CNT_SAT)
              r_cnt <= r_cnt + 1'b1;
          end
          if (w_clk_fall)
            r_miso <= r_shift[DW-1];
          if (w_csn_rise)
            r_state <= COMMIT;
        end
        COMMIT: begin
          if (r_cnt == CNT_FULL) begin
            r_active     <= r_shift;
            r_cfg_update <= 1'b1;
            r_frame_err  <= 1'b0;
          end else begin
            r_frame_err  <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_ovr = r_active[P_OVR];

  // Config outputs: SPI override selects register fields over pin straps
  always_comb begin
    acc_inc        = r_active[N-1:0];
    df_inc         = r_active[P_DAC-1:P_DF];
    dac_ena        = r_active[P_DITH-1:P_DAC];
    usb_i2sn       = usb_i2sn_pin;
    audio_chan_sel = audio_chan_sel_pin;
    i2s_ws_align   = i2s_ws_align_pin;
    dith_fact      = dith_disable_pin ? 3'd0 : r_active[P_USB-1:P_DITH];
    if (w_ovr) begin
      usb_i2sn       = r_active[P_USB];
      audio_chan_sel = r_active[P_AUD];
      i2s_ws_align   = r_active[P_WS];
      dith_fact      = r_active[P_USB-1:P_DITH];
    end
  end

  assign spi.spi_miso = r_miso;
  assign cfg_update   = r_cfg_update;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spi_cfg_loader.sv
// Directed bench for spi_cfg_loader: defaults, good/bad frames,
// readback, transfer stability and reset in the middle of a frame.
module tb_spi_cfg_loader;

  localparam int N = 18;
  localparam int L = 12;
  localparam int D = 5;

  localparam logic [41:0] F_DEF =
    {1'b0, 3'b000, 3'd2, 5'h1F, 12'd393, 18'd52428};
  localparam logic [41:0] F1 =
    {1'b1, 3'b101, 3'd3, 5'h03, 12'd100, 18'd1000};
  localparam logic [41:0] F2 =
    {1'b0, 3'b010, 3'd6, 5'h1A, 12'd2047, 18'd200000};

  logic clk = 1'b0;
  logic rst;
  logic usb_i2sn_pin;
  logic audio_chan_sel_pin;
  logic i2s_ws_align_pin;
  logic dith_disable_pin;
  logic [N-1:0] acc_inc;
  logic [L-1:0] df_inc;
  logic [D-1:0] dac_ena;
  logic [2:0]   dith_fact;
  logic usb_i2sn;
  logic audio_chan_sel;
  logic i2s_ws_align;
  logic cfg_update;
  logic frame_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [63:0] rd;
  int np;
  int lat;

  spi_cfg_loader_if sif ();

  always #5 clk = ~clk;

  spi_cfg_loader dut (
    .clk                (clk),
    .rst                (rst),
    .spi                (sif),
    .usb_i2sn_pin       (usb_i2sn_pin),
    .audio_chan_sel_pin (audio_chan_sel_pin),
    .i2s_ws_align_pin   (i2s_ws_align_pin),
    .dith_disable_pin   (dith_disable_pin),
    .acc_inc            (acc_inc),
    .df_inc             (df_inc),
    .dac_ena            (dac_ena),
    .dith_fact          (dith_fact),
    .usb_i2sn           (usb_i2sn),
    .audio_chan_sel     (audio_chan_sel),
    .i2s_ws_align       (i2s_ws_align),
    .cfg_update         (cfg_update),
    .frame_err          (frame_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bits(input logic [63:0] d, input int n,
                          input bit stab, input logic [N-1:0] exp_acc,
                          output logic [63:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      sif.spi_mosi = d[n-1-i];
      repeat (5) @(negedge clk);
      r = {r[62:0], sif.spi_miso};
      sif.spi_clk = 1'b1;
      repeat (5) @(negedge clk);
      sif.spi_clk = 1'b0;
      if (stab) begin
        chk("stable_acc", 64'(acc_inc), 64'(exp_acc));
        chk("no_pulse_mid", 64'(cfg_update), 64'd0);
      end
    end
  endtask

  task automatic send_frame(input logic [63:0] d, input int n,
                            input logic [N-1:0] exp_acc,
                            output logic [63:0] r,
                            output int pulses, output int first);
    sif.spi_csn = 1'b0;
    repeat (5) @(negedge clk);
    clk_bits(d, n, 1'b1, exp_acc, r);
    repeat (5) @(negedge clk);
    sif.spi_csn = 1'b1;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cfg_update) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    sif.spi_clk        = 1'b0;
    sif.spi_csn        = 1'b1;
    sif.spi_mosi       = 1'b0;
    usb_i2sn_pin       = 1'b1;
    audio_chan_sel_pin = 1'b0;
    i2s_ws_align_pin   = 1'b1;
    dith_disable_pin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    chk("rst_acc", 64'(acc_inc), 64'd52428);
    chk("rst_df", 64'(df_inc), 64'd393);
    chk("rst_dac", 64'(dac_ena), 64'h1F);
    chk("rst_dith", 64'(dith_fact), 64'd2);
    chk("rst_upd", 64'(cfg_update), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_miso", 64'(sif.spi_miso), 64'd0);
    chk("pin_usb", 64'(usb_i2sn), 64'd1);
    chk("pin_aud", 64'(audio_chan_sel), 64'd0);
    chk("pin_ws", 64'(i2s_ws_align), 64'd1);
    dith_disable_pin = 1'b1;
    @(negedge clk);
    chk("rst_dith_dis", 64'(dith_fact), 64'd0);

    usb_i2sn_pin       = 1'b0;
    audio_chan_sel_pin = 1'b1;
    i2s_ws_align_pin   = 1'b0;
    send_frame(64'(F1), 42, 18'd52428, rd, np, lat);
    chk("f1_pulses", 64'(np), 64'd1);
    chk("f1_lat_le5", 64'(lat >= 1 && lat <= 5), 64'd1);
    chk("f1_rdback_def", 64'(rd[41:0]), 64'(F_DEF));
    chk("f1_acc", 64'(acc_inc), 64'd1000);
    chk("f1_df", 64'(df_inc), 64'd100);
    chk("f1_dac", 64'(dac_ena), 64'h03);
    chk("f1_dith", 64'(dith_fact), 64'd3);
    chk("f1_usb", 64'(usb_i2sn), 64'd1);
    chk("f1_aud", 64'(audio_chan_sel), 64'd0);
    chk("f1_ws", 64'(i2s_ws_align), 64'd1);
    chk("f1_err", 64'(frame_err), 64'd0);

    send_frame(64'(F2), 41, 18'd1000, rd, np, lat);
    chk("short_pulses", 64'(np), 64'd0);
    chk("short_err", 64'(frame_err), 64'd1);
    chk("short_acc", 64'(acc_inc), 64'd1000);
    chk("short_df", 64'(df_inc), 64'd100);

    send_frame({F2, 1'b1}, 43, 18'd1000, rd, np, lat);
    chk("long_pulses", 64'(np), 64'd0);
    chk("long_err", 64'(frame_err), 64'd1);
    chk("long_acc", 64'(acc_inc), 64'd1000);
    chk("long_dac", 64'(dac_ena), 64'h03);

    dith_disable_pin = 1'b0;
    send_frame(64'(F2), 42, 18'd1000, rd, np, lat);
    chk("f2_pulses", 64'(np), 64'd1);
    chk("f2_rdback_f1", 64'(rd[41:0]), 64'(F1));
    chk("f2_err_clr", 64'(frame_err), 64'd0);
    chk("f2_acc", 64'(acc_inc), 64'd200000);
    chk("f2_df", 64'(df_inc), 64'd2047);
    chk("f2_dac", 64'(dac_ena), 64'h1A);
    chk("f2_dith", 64'(dith_fact), 64'd6);
    chk("f2_usb_pin", 64'(usb_i2sn), 64'd0);
    chk("f2_aud_pin", 64'(audio_chan_sel), 64'd1);
    chk("f2_ws_pin", 64'(i2s_ws_align), 64'd0);
    dith_disable_pin = 1'b1;
    usb_i2sn_pin     = 1'b1;
    @(negedge clk);
    chk("f2_dith_dis", 64'(dith_fact), 64'd0);
    chk("f2_usb_pin2", 64'(usb_i2sn), 64'd1);

    sif.spi_csn = 1'b0;
    repeat (5) @(negedge clk);
    clk_bits(64'(F1), 20, 1'b1, 18'd200000, rd);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_acc", 64'(acc_inc), 64'd52428);
    chk("mrst_dac", 64'(dac_ena), 64'h1F);
    chk("mrst_miso", 64'(sif.spi_miso), 64'd0);
    clk_bits(64'(F1), 22, 1'b0, 18'd0, rd);
    repeat (5) @(negedge clk);
    sif.spi_csn = 1'b1;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cfg_update) np++;
    end
    chk("mrst_no_pulse", 64'(np), 64'd0);
    chk("mrst_acc2", 64'(acc_inc), 64'd52428);
    chk("mrst_err", 64'(frame_err), 64'd0);

    send_frame(64'(F1), 42, 18'd52428, rd, np, lat);
    chk("post_pulses", 64'(np), 64'd1);
    chk("post_acc", 64'(acc_inc), 64'd1000);
    chk("post_df", 64'(df_inc), 64'd100);
    chk("post_usb", 64'(usb_i2sn), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_cfg_loader.md
Name: spi_cfg_loader

Overview:
System-clock-domain SPI configuration loader for the FM transmitter.
- Oversamples the external SPI pins and shifts in a DW-bit configuration frame.
- Commits the frame atomically to the active config registers, and only on a correct bit count. Config outputs never toggle during a transfer.
- Shifts the previous active config out on MISO for readback.
- Drives acc_inc, df_inc, dac_ena, dith_fact and the mode flags consumed by the phase accumulator, FM modulator, dither and audio front-end.

Parameters:
N, 18, phase accumulator increment width
L, 12, frequency deviation increment width
D, 5, DAC enable width
ACC_INC_DEF, 52428, reset acc_inc (2^18 / (50 MHz / 10 MHz))
DF_INC_DEF, 393, reset df_inc (2^18 / floor(50 MHz / 75 kHz))
DAC_ENA_DEF, all ones, reset dac_ena
DITH_FACT_DEF, 2, reset dith_fact
DW (local), N+L+D+7 = 42, frame length in bits

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous reset, active-high
spi_clk  in  1  SPI clock pin (mode 0), asynchronous to clk
spi_csn  in  1  SPI chip select pin, active-low
spi_mosi  in  1  SPI data in, MSB first
spi_miso  out  1  readback data
usb_i2sn_pin  in  1  pin-strap audio source select
audio_chan_sel_pin  in  1  pin-strap channel select
i2s_ws_align_pin  in  1  pin-strap I2S alignment
dith_disable_pin  in  1  pin-strap dither disable
acc_inc  out  N  active carrier increment
df_inc  out  L  active deviation increment
dac_ena  out  D  active DAC bit enables
dith_fact  out  3  effective dither factor
usb_i2sn  out  1  effective audio source select
audio_chan_sel  out  1  effective channel select
i2s_ws_align  out  1  effective I2S alignment
cfg_update  out  1  one-cycle pulse on commit
frame_err  out  1  sticky; set on a bad-length frame, cleared on the next good commit

Behaviour:
Active register layout, LSB upward:
- acc_inc [N-1:0]
- df_inc next L bits
- dac_ena next D bits
- dith_fact next 3 bits
- usb_i2sn, audio_chan_sel, i2s_ws_align, one bit each
- spi_override at the MSB (bit DW-1)

Input synchronisation:
- spi_clk, spi_csn, spi_mosi each pass a 2-FF synchroniser, then one edge-detect register.
- Pin-to-event latency is 3 clk cycles.
- spi_clk must not exceed f_clk/8, with high and low times of at least 3 clk each.

Reset:
- Active register takes the *_DEF values; flags and spi_override are 0.
- shift register is 0; bit counter is 0; state is IDLE.
- cfg_update = 0, frame_err = 0, spi_miso = 0.
- Synchroniser flops for spi_csn reset to 1, others to 0.
- Reset mid-frame discards the frame and restores defaults.

FSM states: IDLE, SHIFT, COMMIT.
- IDLE: wait for a synchronised csn falling edge. Then load shift_reg with the active register, drive spi_miso = active[DW-1], clear the counter, and go to SHIFT. If csn is low when reset releases, no frame starts until csn has been high, then falls.
- SHIFT, spi_clk rising edge: shift_reg <= {shift_reg[DW-2:0], mosi_sync}. The counter increments and saturates at DW+1.
- SHIFT, spi_clk falling edge: spi_miso <= shift_reg[DW-1].
- SHIFT, csn rising edge: go to COMMIT. A csn rising edge in the same cycle as a spi_clk rising edge counts the bit first.
- COMMIT, counter == DW: active <= shift_reg, cfg_update = 1 for exactly this cycle, frame_err <= 0.
- COMMIT, counter != DW: active is unchanged, frame_err <= 1, no pulse.
- COMMIT always returns to IDLE next cycle.
- New outputs are visible the cycle after COMMIT.

Output muxing (combinational from active register and pins):
- spi_override = 0: usb_i2sn, audio_chan_sel and i2s_ws_align follow their pins. dith_fact = 0 if dith_disable_pin = 1, else the register field.
- spi_override = 1: all four come from the register; the pins are ignored.
- acc_inc, df_inc and dac_ena always come from the register.

Test Plan:
- Reset, no SPI activity -> acc_inc=52428, df_inc=393, dac_ena=5'h1F, dith_fact=2 with dith_disable_pin=0, and 0 with the pin at 1; cfg_update=0; frame_err=0.
- 42-bit frame with override=1, flags=3'b101, dith=3, dac=5'h03, df=100, acc=1000 -> one cfg_update pulse ≤5 clk after csn rises; outputs match the frame; pins ignored.
- 41-bit frame and 43-bit frame -> outputs unchanged, frame_err=1, no pulse; a following good frame clears frame_err.
- Readback: after a commit, send a second 42-bit frame -> MISO bits equal the first frame, MSB first.
- Outputs stay stable throughout a transfer; they change only in the cycle after COMMIT.
- Assert rst at bit 20 of a frame -> defaults restored; frame ignored; the next frame started after csn goes high commits normally.
